// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray counter push-button sequencer:
// FSM state encoding and a width helper for the hold/rate counters.
package gray_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS    = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } ctrl_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gray_step_ctrl.sv
// Push-button sequencer: turns a debounced button into single steps,
// auto-repeat steps while held, and a counter clear on a very long hold.
// Also keeps a binary shadow count of issued steps.
module gray_step_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int N        = 8,
    parameter int HOLD_CYC = 16,
    parameter int RATE_CYC = 4,
    parameter int CLR_CYC  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn,
    output logic         cnt_en,
    output logic         cnt_clr,
    output logic         busy,
    output logic [N-1:0] pulse_cnt
);

    localparam int TW = cnt_width(CLR_CYC - 1);
    localparam int RW = cnt_width(RATE_CYC - 1);

    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_CYC - 1);
    localparam logic [RW-1:0] RATE_ONE   = RW'(1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RATE_CYC - 1);
    localparam logic [N-1:0]  PCNT_ONE   = N'(1);

    ctrl_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] rate_q, rate_d;
    logic [N-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          busy_q, busy_d;
    logic          btn_q;
    logic          rise;

    // A button held through reset release must not look like a new press,
    // hence btn_q resets high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            rate_q      <= '0;
            pulse_cnt_q <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rate_q      <= rate_d;
            pulse_cnt_q <= pulse_cnt_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            busy_q      <= busy_d;
            btn_q       <= btn;
        end
    end

    // Next-state, pulse generation and shadow count; release always wins
    // over a threshold reached at the same edge.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rate_d      = rate_q;
        cnt_en_d    = 1'b0;
        cnt_clr_d   = 1'b0;
        pulse_cnt_d = pulse_cnt_q;
        rise        = btn & ~btn_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_PRESS;
                    cnt_en_d = 1'b1;
                    timer_d  = TIMER_ONE;
                end
            end
            ST_PRESS: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    state_d  = ST_REPEAT;
                    cnt_en_d = 1'b1;
                    rate_d   = '0;
                    timer_d  = timer_q + TIMER_ONE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    rate_d  = '0;
                end else if (timer_q == CLR_LAST) begin
                    // The clear replaces any step that falls due here.
                    state_d   = ST_WAIT_REL;
                    cnt_clr_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                    if (rate_q == RATE_LAST) begin
                        cnt_en_d = 1'b1;
                        rate_d   = '0;
                    end else begin
                        rate_d = rate_q + RATE_ONE;
                    end
                end
            end
            ST_WAIT_REL: begin
                if (!btn) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    rate_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cnt_clr_d) begin
            pulse_cnt_d = '0;
        end else if (cnt_en_d) begin
            pulse_cnt_d = pulse_cnt_q + PCNT_ONE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign busy      = busy_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Scoreboard bench for gray_step_ctrl: each button press is translated into
// the list of expected step/clear events (edge offset and shadow count),
// and a monitor matches every pulse the DUT emits against that list.
module tb_gray_step_ctrl;

    localparam int N        = 8;
    localparam int HOLD_CYC = 8;
    localparam int RATE_CYC = 3;
    localparam int CLR_CYC  = 32;

    localparam logic [1:0] K_STEP  = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b01;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
        int         cnt;
    } ev_t;

    logic         clk;
    logic         reset;
    logic         btn;
    logic         cnt_en;
    logic         cnt_clr;
    logic         busy;
    logic [N-1:0] pulse_cnt;

    ev_t exp_q[$];
    int  cyc;
    int  total;
    int  bad;
    int  model_cnt;

    gray_step_ctrl #(
        .N(N), .HOLD_CYC(HOLD_CYC), .RATE_CYC(RATE_CYC), .CLR_CYC(CLR_CYC)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .pulse_cnt(pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input int at);
        ev_t e;
        if (kind == K_STEP) model_cnt = (model_cnt + 1) % (1 << N);
        else                model_cnt = 0;
        e.kind = kind;
        e.cyc  = at;
        e.cnt  = model_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected pulses for a press sampled high on edges 0..len-1:
    // a step at 0, steps from HOLD_CYC-1 every RATE_CYC while still held and
    // before the clear point, and a clear at CLR_CYC-1 if still held there.
    task automatic model_press(input int base, input int len);
        int t;
        push_ev(K_STEP, base);
        t = HOLD_CYC - 1;
        while (t < len && t < CLR_CYC - 1) begin
            push_ev(K_STEP, base + t);
            t += RATE_CYC;
        end
        if (len > CLR_CYC - 1) push_ev(K_CLEAR, base + CLR_CYC - 1);
    endtask

    // Called just after a rising edge with btn low and the DUT idle.
    task automatic press(input int len, input int gap);
        model_press(cyc + 1, len);
        btn = 1'b1;
        step_edges(1);
        check("busy_after_press", int'(busy), 1);
        step_edges(len - 1);
        btn = 1'b0;
        step_edges(gap);
        check("busy_after_release", int'(busy), 0);
        check("pulse_cnt_after_release", int'(pulse_cnt), model_cnt);
        $display("press len=%0d gap=%0d pulse_cnt=%0d", len, gap, pulse_cnt);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && (cnt_en || cnt_clr)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got en=%0b clr=%0b expected none (cyc %0d)",
                         cnt_en, cnt_clr, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_kind", int'({cnt_en, cnt_clr}), int'(e.kind));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_count", int'(pulse_cnt), e.cnt);
                $display("pulse en=%0b clr=%0b cyc=%0d cnt=%0d", cnt_en, cnt_clr, cyc, pulse_cnt);
            end
        end
    end

    initial begin
        cyc       = 0;
        total     = 0;
        bad       = 0;
        model_cnt = 0;
        reset     = 1'b0;
        btn       = 1'b1;

        // Reset with the button held through release: nothing may happen.
        step_edges(3);
        #2;
        reset = 1'b1;
        #1;
        check("reset_cnt_en", int'(cnt_en), 0);
        check("reset_cnt_clr", int'(cnt_clr), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_pulse_cnt", int'(pulse_cnt), 0);
        @(posedge clk);
        #1;
        step_edges(10);
        check("held_through_reset_busy", int'(busy), 0);
        check("held_through_reset_cnt", int'(pulse_cnt), 0);
        btn = 1'b0;
        step_edges(2);

        // Directed presses from the plan.
        press(3, 2);
        press(20, 2);
        press(40, 3);
        press(7, 2);
        press(HOLD_CYC, 1);

        // Randomized hold lengths spanning all regions.
        for (int i = 0; i < 8; i++) begin
            press(int'($urandom_range(1, 45)), int'($urandom_range(1, 3)));
        end

        // Reset asserted mid-REPEAT, between clock edges.
        model_press(cyc + 1, 12);
        btn = 1'b1;
        step_edges(12);
        check("pre_reset_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_cnt_en", int'(cnt_en), 0);
        check("async_reset_cnt_clr", int'(cnt_clr), 0);
        check("async_reset_pulse_cnt", int'(pulse_cnt), 0);
        model_cnt = 0;
        step_edges(2);
        #2;
        reset = 1'b1;
        step_edges(12);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_pulse_cnt", int'(pulse_cnt), 0);
        btn = 1'b0;
        step_edges(2);

        // Wrap: 256 short presses return the shadow count to zero.
        for (int i = 0; i < (1 << N); i++) begin
            model_press(cyc + 1, 2);
            btn = 1'b1;
            step_edges(2);
            btn = 1'b0;
            step_edges(1);
        end
        check("wrap_pulse_cnt", int'(pulse_cnt), 0);
        press(1, 2);
        check("after_wrap_pulse_cnt", int'(pulse_cnt), 1);

        step_edges(4);
        check("outstanding_events", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
